hybrid_crypto_ctrl: RTL and testbench

Sequencer for the hybrid AES+RSA datapath. It accepts 128-bit block requests through a valid/ready handshake and manages the session key. When a new session key is required, it starts the RSA key-wrap core and the AES core in parallel. It collects both single-cycle done pulses, in any order, and returns the AES result and, when the key was refreshed, the wrapped key through a valid/ready response port. It sits between the host/bus front end and the AES and RSA cores, and is the only driver of their start strobes.

---
 rtl/hybrid_crypto_ctrl_if.sv | 29 ++
 rtl/hybrid_crypto_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hybrid_crypto_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hybrid_crypto_ctrl_if.sv
// Host-side request/response channels of the hybrid AES+RSA sequencer.
// master = host/bus front end, slave = hybrid_crypto_ctrl.
interface hybrid_crypto_ctrl_if #(
  parameter int W = 1024
) ();
  logic           req_valid;
  logic           req_ready;
  logic           req_enc_dec;
  logic           req_new_key;
  logic [W-1:0]   req_key;
  logic [127:0]   req_data;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [127:0]   rsp_data;
  logic [2*W-1:0] rsp_enc_key;
  logic           rsp_key_fresh;
  logic           rsp_err;

  modport master (
    output req_valid, req_enc_dec, req_new_key, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_enc_key, rsp_key_fresh, rsp_err
  );

  modport slave (
    input  req_valid, req_enc_dec, req_new_key, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_enc_key, rsp_key_fresh, rsp_err
  );
endinterface

// File: rtl/hybrid_crypto_ctrl.sv
// Sequencer launching the AES core and (on rekey) the RSA key-wrap core in parallel.
// Optional HYB_STATS_EN adds saturating blk_cnt / rekey_cnt outputs.
module hybrid_crypto_ctrl #(
  parameter int W       = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  hybrid_crypto_ctrl_if.slave host,

  output logic             aes_start,
  output logic             aes_enc_dec,
  output logic [W-1:0]     aes_key,
  output logic [127:0]     aes_d_in,
  input  logic             aes_done,
  input  logic [127:0]     aes_d_out,

  output logic             rsa_start,
  output logic [W-1:0]     rsa_key,
  input  logic             rsa_done,
  input  logic [2*W-1:0]   rsa_enc_key,

  output logic             busy
`ifdef HYB_STATS_EN
  ,
  output logic [31:0]      blk_cnt,
  output logic [15:0]      rekey_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic            rekey;
  logic            key_valid;
  logic [W-1:0]    sess_key;
  logic            aes_flag;
  logic            rsa_flag;
  logic [CW-1:0]   tmo_cnt;

  logic            aes_flag_nx;
  logic            rsa_flag_nx;
  logic            need;
  logic            do_rekey;

  // NOTE: every variable gets a value on every path here, so no latch can be inferred.
  always_comb begin
    aes_flag_nx = aes_flag | aes_done;
    rsa_flag_nx = rsa_flag | (rsa_done & rekey);
    need        = aes_flag_nx & (rsa_flag_nx | ~rekey);
    do_rekey    = host.req_new_key | ~key_valid;
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: wide key/data registers are reset as well so no stale key survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      host.req_ready     <= 1'b0;
      host.rsp_valid     <= 1'b0;
      host.rsp_data      <= '0;
      host.rsp_enc_key   <= '0;
      host.rsp_key_fresh <= 1'b0;
      host.rsp_err       <= 1'b0;
      aes_start          <= 1'b0;
      aes_enc_dec        <= 1'b0;
      aes_key            <= '0;
      aes_d_in           <= '0;
      rsa_start          <= 1'b0;
      rsa_key            <= '0;
      busy               <= 1'b0;
      rekey              <= 1'b0;
      key_valid          <= 1'b0;
      sess_key           <= '0;
      aes_flag           <= 1'b0;
      rsa_flag           <= 1'b0;
      tmo_cnt            <= '0;
    end else begin
      aes_start <= 1'b0;
      rsa_start <= 1'b0;

      unique case (state)
        IDLE: begin
          host.req_ready <= 1'b1;
          if (host.req_valid && host.req_ready) begin
            state          <= LAUNCH;
            host.req_ready <= 1'b0;
            busy           <= 1'b1;
            rekey          <= do_rekey;
            aes_enc_dec    <= host.req_enc_dec;
            aes_d_in       <= host.req_data;
            aes_start      <= 1'b1;
            rsa_start      <= do_rekey;
            if (do_rekey) begin
              aes_key <= host.req_key;
              rsa_key <= host.req_key;
            end else begin
              aes_key <= sess_key;
            end
          end
        end

        LAUNCH: begin
          aes_flag <= 1'b0;
          rsa_flag <= 1'b0;
          tmo_cnt  <= '0;
          state    <= RUN;
        end

        RUN: begin
          aes_flag <= aes_flag_nx;
          rsa_flag <= rsa_flag_nx;
          tmo_cnt  <= tmo_cnt + CW'(1);
          if (aes_done)
            host.rsp_data <= aes_d_out;
          if (rsa_done && rekey)
            host.rsp_enc_key <= rsa_enc_key;

          if (need) begin
            state              <= RESP;
            host.rsp_valid     <= 1'b1;
            host.rsp_key_fresh <= rekey;
            host.rsp_err       <= 1'b0;
            if (rekey) begin
              key_valid <= 1'b1;
              sess_key  <= aes_key;
            end
          end else if (tmo_cnt == T_LAST) begin
            // Abort: the response carries no data and the next job must rekey.
            state              <= RESP;
            host.rsp_valid     <= 1'b1;
            host.rsp_key_fresh <= 1'b0;
            host.rsp_err       <= 1'b1;
            host.rsp_data      <= '0;
            key_valid          <= 1'b0;
          end
        end

        RESP: begin
          if (host.rsp_ready) begin
            state          <= IDLE;
            host.rsp_valid <= 1'b0;
            host.req_ready <= 1'b1;
            busy           <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef HYB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt   <= '0;
      rekey_cnt <= '0;
    end else begin
      if (state == RESP && host.rsp_ready && !host.rsp_err && blk_cnt != '1)
        blk_cnt <= blk_cnt + 32'd1;
      if (state == RUN && need && rekey && rekey_cnt != '1)
        rekey_cnt <= rekey_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_crypto_ctrl.sv
// Scoreboard bench for hybrid_crypto_ctrl with latency-programmable AES/RSA stubs,
// plus a second instance with TIMEOUT=16 for the abort path.
module tb_hybrid_crypto_ctrl;
  localparam int W = 256;

  typedef logic [511:0] v_t;

  typedef struct {
    logic [127:0]   data;
    logic [2*W-1:0] enc;
    logic           fresh;
    logic           err;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance ----------------
  hybrid_crypto_ctrl_if #(.W(W)) host ();
  logic             aes_start, aes_enc_dec, aes_done;
  logic [W-1:0]     aes_key;
  logic [127:0]     aes_d_in;
  logic [127:0]     aes_d_out = '1;
  logic             rsa_start, rsa_done;
  logic [W-1:0]     rsa_key;
  logic [2*W-1:0]   rsa_enc_key = '1;
  logic             busy;
  logic aes_done_stub = 1'b0, aes_done_stray = 1'b0;
  logic rsa_done_stub = 1'b0, rsa_done_stray = 1'b0;
  assign aes_done = aes_done_stub | aes_done_stray;
  assign rsa_done = rsa_done_stub | rsa_done_stray;
`ifdef HYB_STATS_EN
  logic [31:0] blk_cnt;
  logic [15:0] rekey_cnt;
`endif

  hybrid_crypto_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .host(host),
    .aes_start(aes_start), .aes_enc_dec(aes_enc_dec), .aes_key(aes_key), .aes_d_in(aes_d_in),
    .aes_done(aes_done), .aes_d_out(aes_d_out),
    .rsa_start(rsa_start), .rsa_key(rsa_key), .rsa_done(rsa_done), .rsa_enc_key(rsa_enc_key),
    .busy(busy)
`ifdef HYB_STATS_EN
    , .blk_cnt(blk_cnt), .rekey_cnt(rekey_cnt)
`endif
  );

  // ---------------- timeout instance ----------------
  hybrid_crypto_ctrl_if #(.W(W)) ht ();
  logic             t_aes_start, t_aes_enc_dec, t_rsa_start, t_busy;
  logic [W-1:0]     t_aes_key, t_rsa_key;
  logic [127:0]     t_aes_d_in;
  logic             t_aes_done = 1'b0, t_rsa_done = 1'b0;
  logic [127:0]     t_aes_d_out = '0;
  logic [2*W-1:0]   t_rsa_enc_key = '0;
`ifdef HYB_STATS_EN
  logic [31:0] t_blk_cnt;
  logic [15:0] t_rekey_cnt;
`endif

  hybrid_crypto_ctrl #(.W(W), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .host(ht),
    .aes_start(t_aes_start), .aes_enc_dec(t_aes_enc_dec), .aes_key(t_aes_key), .aes_d_in(t_aes_d_in),
    .aes_done(t_aes_done), .aes_d_out(t_aes_d_out),
    .rsa_start(t_rsa_start), .rsa_key(t_rsa_key), .rsa_done(t_rsa_done), .rsa_enc_key(t_rsa_enc_key),
    .busy(t_busy)
`ifdef HYB_STATS_EN
    , .blk_cnt(t_blk_cnt), .rekey_cnt(t_rekey_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] aes_fn(input logic [127:0] d, input logic [W-1:0] k, input logic e);
    return e ? (d ^ k[127:0]) : ({d[63:0], d[127:64]} ^ k[127:0]);
  endfunction

  function automatic logic [2*W-1:0] rsa_fn(input logic [W-1:0] k);
    return {~k, k ^ {(W/8){8'h5a}}};
  endfunction

  // ---------------- core stubs ----------------
  int aes_lat = 1;
  int rsa_lat = 1;

  initial begin : aes_stub
    int lat;
    forever begin
      @(negedge clk);
      if (aes_start && !rst) begin
        lat = aes_lat;
        repeat (lat) @(negedge clk);
        aes_d_out     = aes_fn(aes_d_in, aes_key, aes_enc_dec);
        aes_done_stub = 1'b1;
        @(negedge clk);
        aes_done_stub = 1'b0;
        aes_d_out     = '1;
      end
    end
  end

  initial begin : rsa_stub
    int lat;
    forever begin
      @(negedge clk);
      if (rsa_start && !rst && rsa_lat > 0) begin
        lat = rsa_lat;
        repeat (lat) @(negedge clk);
        rsa_enc_key   = rsa_fn(rsa_key);
        rsa_done_stub = 1'b1;
        @(negedge clk);
        rsa_done_stub = 1'b0;
        rsa_enc_key   = '1;
      end
    end
  end

  // ---------------- scoreboard and response monitor ----------------
  exp_t           sb[$];
  logic           kv_m = 1'b0;
  logic [W-1:0]   sess_m = '0;
  logic [2*W-1:0] wrap_m = '0;
  int             blk_m = 0;
  int             rekey_m = 0;

  logic           prev_valid = 1'b0;
  logic           hs_seen = 1'b0;
  logic [127:0]   snap_data;
  logic [2*W-1:0] snap_enc;
  logic           snap_fresh, snap_err;

  initial begin : monitor
    exp_t cur;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_valid = 1'b0;
        hs_seen    = 1'b0;
      end else begin
        if (hs_seen) begin
          check("req_ready_after_hs", v_t'(host.req_ready), v_t'(1));
          check("busy_after_hs", v_t'(busy), v_t'(0));
        end
        hs_seen = host.rsp_valid && host.rsp_ready;
        if (host.rsp_valid) begin
          if (!prev_valid) begin
            if (sb.size() == 0) begin
              check("rsp_unexpected", v_t'(1), v_t'(0));
            end else begin
              cur = sb.pop_front();
              check("rsp_cycle", v_t'(cyc), v_t'(cur.cyc));
              check("rsp_data", v_t'(host.rsp_data), v_t'(cur.data));
              check("rsp_enc_key", v_t'(host.rsp_enc_key), v_t'(cur.enc));
              check("rsp_key_fresh", v_t'(host.rsp_key_fresh), v_t'(cur.fresh));
              check("rsp_err", v_t'(host.rsp_err), v_t'(cur.err));
            end
            snap_data  = host.rsp_data;
            snap_enc   = host.rsp_enc_key;
            snap_fresh = host.rsp_key_fresh;
            snap_err   = host.rsp_err;
          end else begin
            check("hold_data", v_t'(host.rsp_data), v_t'(snap_data));
            check("hold_enc_key", v_t'(host.rsp_enc_key), v_t'(snap_enc));
            check("hold_fresh", v_t'(host.rsp_key_fresh), v_t'(snap_fresh));
            check("hold_err", v_t'(host.rsp_err), v_t'(snap_err));
          end
          check("req_ready_in_resp", v_t'(host.req_ready), v_t'(0));
        end
        prev_valid = host.rsp_valid && !host.rsp_ready;
      end
    end
  end

  // Drive one request, push its expected response, and check the launch strobes.
  task automatic do_req(input logic enc, input logic nk, input logic [W-1:0] key,
                        input logic [127:0] data, input int al, input int rl);
    exp_t         e;
    logic         rk;
    logic [W-1:0] k_used;
    int           fin;
    int           g;
    int           t;
    aes_lat = al;
    rsa_lat = rl;
    @(negedge clk);
    host.req_valid   = 1'b1;
    host.req_enc_dec = enc;
    host.req_new_key = nk;
    host.req_key     = key;
    host.req_data    = data;
    g = 0;
    while (!host.req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!host.req_ready) check("req_accept_wait", v_t'(0), v_t'(1));
    t      = cyc;
    rk     = nk | ~kv_m;
    k_used = rk ? key : sess_m;
    e.data  = aes_fn(data, k_used, enc);
    e.fresh = rk;
    e.err   = 1'b0;
    if (rk) begin
      fin    = (al > rl) ? al : rl;
      kv_m   = 1'b1;
      sess_m = key;
      wrap_m = rsa_fn(key);
      rekey_m++;
    end else begin
      fin = al;
    end
    e.enc = wrap_m;
    e.cyc = t + 2 + fin;
    blk_m++;
    sb.push_back(e);

    @(negedge clk);
    host.req_valid = 1'b0;
    check("aes_start_launch", v_t'(aes_start), v_t'(1));
    check("rsa_start_launch", v_t'(rsa_start), v_t'(rk));
    check("aes_key_launch", v_t'(aes_key), v_t'(k_used));
    check("busy_launch", v_t'(busy), v_t'(1));
    @(negedge clk);
    check("aes_start_pulse", v_t'(aes_start), v_t'(0));
    check("rsa_start_pulse", v_t'(rsa_start), v_t'(0));
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while ((sb.size() != 0 || host.rsp_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0 || host.rsp_valid) begin
      check("rsp_wait", v_t'(0), v_t'(1));
      sb.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t;
    int g;
    host.req_valid = 1'b0; host.req_enc_dec = 1'b0; host.req_new_key = 1'b0;
    host.req_key = '0; host.req_data = '0; host.rsp_ready = 1'b1;
    ht.req_valid = 1'b0; ht.req_enc_dec = 1'b0; ht.req_new_key = 1'b0;
    ht.req_key = '0; ht.req_data = '0; ht.rsp_ready = 1'b1;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", v_t'(host.req_ready), v_t'(0));
    check("rst_busy", v_t'(busy), v_t'(0));
    check("rst_aes_start", v_t'(aes_start), v_t'(0));
    check("rst_rsa_start", v_t'(rsa_start), v_t'(0));
    check("rst_rsp_valid", v_t'(host.rsp_valid), v_t'(0));
    check("rst_aes_key", v_t'(aes_key), v_t'(0));
    check("rst_rsp_enc_key", v_t'(host.rsp_enc_key), v_t'(0));
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", v_t'(host.req_ready), v_t'(1));

    // First request rekeys although new_key=0; RSA is the long pole.
    do_req(1'b1, 1'b0, W'(128'h2b28_ab09_7eae_f7cf_15d2_154f_16a6_883c),
           128'h3288_31e0_435a_3137_f630_9807_a88d_a234, 5, 20);
    wait_rsp();
    // Stored key reused, no RSA launch.
    do_req(1'b1, 1'b0, W'(256'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0_1111_2222_3333_4444_5555_6666_7777_8888),
           128'hcafe_babe_dead_beef_0123_4567_89ab_cdef, 5, 20);
    wait_rsp();
    // Simultaneous dones.
    do_req(1'b0, 1'b1, W'(256'ha5a5_0000_ffff_1234_5678_9abc_def0_0f0f_f0f0_1357_9bdf_2468_ace0_7777_8888_9999),
           128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 3, 3);
    wait_rsp();
    // RSA finishes first.
    do_req(1'b1, 1'b1, W'(256'h1234_5678_9abc_def0_fedc_ba98_7654_3210_0000_1111_2222_3333_4444_5555_6666_7777),
           128'hfeed_face_0bad_f00d_1357_2468_ace0_bdf1, 9, 2);
    wait_rsp();

    // Minimum latency, stray rsa_done without rekey, consumer stalls 10 cycles.
    host.rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, W'(256'h9999), 128'h5555_aaaa_5555_aaaa_1234_4321_abcd_dcba, 1, 5);
    rsa_done_stray = 1'b1;
    @(negedge clk);
    rsa_done_stray = 1'b0;
    check("min_latency_valid", v_t'(host.rsp_valid), v_t'(1));
    repeat (10) @(negedge clk);
    host.rsp_ready = 1'b1;
    wait_rsp();

    // Asynchronous reset in RUN, then stray done pulses.
    do_req(1'b1, 1'b1, W'(256'h7777_6666), 128'h0101_0202_0303_0404_0505_0606_0707_0808, 30, 30);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", v_t'(busy), v_t'(0));
    check("midrst_req_ready", v_t'(host.req_ready), v_t'(0));
    check("midrst_rsp_valid", v_t'(host.rsp_valid), v_t'(0));
    check("midrst_aes_start", v_t'(aes_start), v_t'(0));
    check("midrst_rsa_start", v_t'(rsa_start), v_t'(0));
    check("midrst_aes_key", v_t'(aes_key), v_t'(0));
    check("midrst_aes_d_in", v_t'(aes_d_in), v_t'(0));
    check("midrst_rsp_data", v_t'(host.rsp_data), v_t'(0));
    void'(sb.pop_back());
    kv_m = 1'b0; sess_m = '0; wrap_m = '0; blk_m = 0; rekey_m = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      aes_done_stray = (i == 5);
      check("stray_rsp_valid", v_t'(host.rsp_valid), v_t'(0));
      check("stray_busy", v_t'(busy), v_t'(0));
    end
    aes_done_stray = 1'b0;
    // Reset lost key_valid: new_key=0 still rekeys.
    do_req(1'b1, 1'b0, W'(256'h3c3c_c3c3_0f0f_f0f0), 128'h8888_7777_6666_5555_4444_3333_2222_1111, 4, 6);
    wait_rsp();

    // ---- timeout instance: RSA never completes ----
    @(negedge clk);
    ht.req_valid = 1'b1; ht.req_new_key = 1'b1; ht.req_enc_dec = 1'b1;
    ht.req_key = W'(256'habcd); ht.req_data = 128'h1;
    g = 0;
    while (!ht.req_ready && g < 100) begin @(negedge clk); g++; end
    t = cyc;
    @(negedge clk);
    ht.req_valid = 1'b0;
    check("tmo_aes_start", v_t'(t_aes_start), v_t'(1));
    check("tmo_rsa_start", v_t'(t_rsa_start), v_t'(1));
    repeat (2) @(negedge clk);
    t_aes_d_out = 128'h1234_5678;
    t_aes_done  = 1'b1;
    @(negedge clk);
    t_aes_done  = 1'b0;
    g = 0;
    while (!ht.rsp_valid && g < 60) begin @(negedge clk); g++; end
    check("tmo_rsp_cycle", v_t'(cyc), v_t'(t + 18));
    check("tmo_rsp_err", v_t'(ht.rsp_err), v_t'(1));
    check("tmo_rsp_fresh", v_t'(ht.rsp_key_fresh), v_t'(0));
    check("tmo_rsp_data", v_t'(ht.rsp_data), v_t'(0));
    check("tmo_rsp_enc_key", v_t'(ht.rsp_enc_key), v_t'(0));
    @(negedge clk);
    ht.req_valid = 1'b1; ht.req_new_key = 1'b0; ht.req_enc_dec = 1'b0;
    ht.req_key = W'(256'h4242_4242); ht.req_data = 128'h2;
    g = 0;
    while (!ht.req_ready && g < 100) begin @(negedge clk); g++; end
    t = cyc;
    @(negedge clk);
    ht.req_valid = 1'b0;
    check("tmo_rekey_rsa_start", v_t'(t_rsa_start), v_t'(1));
    check("tmo_rekey_aes_key", v_t'(t_aes_key), v_t'(W'(256'h4242_4242)));
    @(negedge clk);
    t_aes_d_out   = 128'hbeef;
    t_rsa_enc_key = {(2*W/16){16'h6c6c}};
    t_aes_done    = 1'b1;
    t_rsa_done    = 1'b1;
    @(negedge clk);
    t_aes_done = 1'b0;
    t_rsa_done = 1'b0;
    check("tmo2_rsp_cycle", v_t'(cyc), v_t'(t + 3));
    check("tmo2_rsp_valid", v_t'(ht.rsp_valid), v_t'(1));
    check("tmo2_rsp_err", v_t'(ht.rsp_err), v_t'(0));
    check("tmo2_rsp_fresh", v_t'(ht.rsp_key_fresh), v_t'(1));
    check("tmo2_rsp_data", v_t'(ht.rsp_data), v_t'(128'hbeef));
    check("tmo2_rsp_enc_key", v_t'(ht.rsp_enc_key), v_t'({(2*W/16){16'h6c6c}}));
    repeat (2) @(negedge clk);

`ifdef HYB_STATS_EN
    check("blk_cnt", v_t'(blk_cnt), v_t'(blk_m));
    check("rekey_cnt", v_t'(rekey_cnt), v_t'(rekey_m));
    check("t_blk_cnt", v_t'(t_blk_cnt), v_t'(1));
    check("t_rekey_cnt", v_t'(t_rekey_cnt), v_t'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
